// File: rtl/writeback_arbiter_if.sv
// Register-file writeback bus for writeback_arbiter: pipeline, multdiv and exception
// requests in, registered write port and stall out. Forwarding-hit signals exist only with WB_FWD_EN.
interface writeback_arbiter_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              pipe_valid;
    logic              pipe_we;
    logic [REG_W-1:0]  pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              md_valid;
    logic [REG_W-1:0]  md_rd;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;
    logic              exc_valid;
    logic [DATA_W-1:0] exc_code;
    logic              ctrl_writeEnable;
    logic [REG_W-1:0]  ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic              stall;
`ifdef WB_FWD_EN
    logic [REG_W-1:0]  ctrl_readRegA;
    logic [REG_W-1:0]  ctrl_readRegB;
    logic              fwd_hitA;
    logic              fwd_hitB;
`endif

    modport slave (
        input  pipe_valid, pipe_we, pipe_rd, pipe_data,
        input  md_valid, md_rd, md_data,
        input  exc_valid, exc_code,
        output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, stall
`ifdef WB_FWD_EN
        , input  ctrl_readRegA, ctrl_readRegB
        , output fwd_hitA, fwd_hitB
`endif
    );

    modport master (
        output pipe_valid, pipe_we, pipe_rd, pipe_data,
        output md_valid, md_rd, md_data,
        output exc_valid, exc_code,
        input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, stall
`ifdef WB_FWD_EN
        , output ctrl_readRegA, ctrl_readRegB
        , input  fwd_hitA, fwd_hitB
`endif
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: exception > starved multdiv buffer > pipeline > buffer.
// Optional forwarding-hit outputs are enabled by defining WB_FWD_EN.
module writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    writeback_arbiter_if.slave wb
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [REG_W-1:0] EXC_RD = REG_W'(30);

    typedef enum logic [1:0] {IDLE, HELD, FORCE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              buf_valid;
    logic [REG_W-1:0]  buf_rd;
    logic [DATA_W-1:0] buf_data;

    logic              sel_valid;
    logic [REG_W-1:0]  sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              buf_win;
    logic              pipe_win;
    logic              pipe_req;

    assign pipe_req    = wb.pipe_valid && wb.pipe_we;
    assign wb.md_ready = !buf_valid;
    assign wb.stall    = (state == FORCE) && pipe_req && !wb.exc_valid;

    // Per-cycle winner selection
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        buf_win   = 1'b0;
        pipe_win  = 1'b0;
        if (wb.exc_valid) begin
            sel_valid = 1'b1;
            sel_rd    = EXC_RD;
            sel_data  = wb.exc_code;
        end else if (state == FORCE) begin
            buf_win = 1'b1;
        end else if (pipe_req) begin
            pipe_win = 1'b1;
        end else if (buf_valid) begin
            buf_win = 1'b1;
        end
        if (buf_win) begin
            sel_valid = 1'b1;
            sel_rd    = buf_rd;
            sel_data  = buf_data;
        end else if (pipe_win) begin
            sel_valid = 1'b1;
            sel_rd    = wb.pipe_rd;
            sel_data  = wb.pipe_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state               <= IDLE;
            count               <= '0;
            buf_valid           <= 1'b0;
            buf_rd              <= '0;
            buf_data            <= '0;
            wb.ctrl_writeEnable <= 1'b0;
            wb.ctrl_writeReg    <= '0;
            wb.data_writeReg    <= '0;
        end else begin
            // A write to r0 is consumed but never enabled
            wb.ctrl_writeEnable <= sel_valid && (sel_rd != '0);
            wb.ctrl_writeReg    <= sel_rd;
            wb.data_writeReg    <= sel_data;

            if (buf_win) begin
                buf_valid <= 1'b0;
            end else if (wb.md_valid && !buf_valid) begin
                buf_valid <= 1'b1;
                buf_rd    <= wb.md_rd;
                buf_data  <= wb.md_data;
            end

            case (state)
                IDLE: begin
                    count <= '0;
                    if (wb.md_valid && !buf_valid) state <= HELD;
                end
                HELD: begin
                    if (buf_win) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (pipe_win) begin
                        count <= count + CNT_W'(1);
                        if (count + CNT_W'(1) >= CNT_W'(STARVE_LIMIT)) state <= FORCE;
                    end
                end
                FORCE: begin
                    if (buf_win) begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

`ifdef WB_FWD_EN
    assign wb.fwd_hitA = wb.ctrl_writeEnable && (wb.ctrl_writeReg == wb.ctrl_readRegA);
    assign wb.fwd_hitB = wb.ctrl_writeEnable && (wb.ctrl_writeReg == wb.ctrl_readRegB);
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by random traffic
// checked against a buffer/loss-count reference model.
module tb_writeback_arbiter;
    localparam int unsigned LIMIT = 4;

    logic clock = 1'b0;
    logic ctrl_reset;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    writeback_arbiter_if bus ();

    writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .wb         (bus)
    );

    always #5 clock = ~clock;

    // Reference model: one pending multdiv result and how often it has lost to the pipeline
    logic        m_bv;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_losses;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_data_care;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pwe, input logic [4:0] prd,
                         input logic [31:0] pd, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] md, input logic ev, input logic [31:0] ec,
                         input logic rst);
        bus.pipe_valid = pv;  bus.pipe_we = pwe; bus.pipe_rd = prd; bus.pipe_data = pd;
        bus.md_valid   = mv;  bus.md_rd   = mrd; bus.md_data = md;
        bus.exc_valid  = ev;  bus.exc_code = ec;
        ctrl_reset     = rst;
`ifdef WB_FWD_EN
        bus.ctrl_readRegA = 5'($urandom_range(0, 31));
        bus.ctrl_readRegB = 5'($urandom_range(0, 31));
`endif
    endtask

    // One clock: check combinational outputs, predict, clock, check the write port
    task automatic tick();
        logic        pipe_wr;
        logic        forced;
        logic        w_valid;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        logic        take_buf;
        logic        pipe_won;
        #1;
        pipe_wr = bus.pipe_valid && bus.pipe_we;
        forced  = m_bv && (m_losses >= int'(LIMIT));
        chk("md_ready", 32'(bus.md_ready), 32'(!m_bv));
        chk("stall", 32'(bus.stall), 32'(forced && pipe_wr && !bus.exc_valid));
        last_stall = bus.stall;

        take_buf = 1'b0; pipe_won = 1'b0;
        w_valid = 1'b1; w_rd = '0; w_data = '0;
        if (bus.exc_valid) begin
            w_rd = 5'd30; w_data = bus.exc_code;
        end else if (forced || (m_bv && !pipe_wr)) begin
            take_buf = 1'b1; w_rd = m_rd; w_data = m_data;
        end else if (pipe_wr) begin
            pipe_won = 1'b1; w_rd = bus.pipe_rd; w_data = bus.pipe_data;
        end else begin
            w_valid = 1'b0;
        end

        if (!ctrl_reset) begin
            m_bv = 1'b0; m_losses = 0;
            e_we = 1'b0; e_rd = '0; e_data = '0; e_data_care = 1'b1;
        end else begin
            e_we        = w_valid && (w_rd != 5'd0);
            e_rd        = w_rd;
            e_data      = w_data;
            e_data_care = !(w_valid && w_rd == 5'd0);
            if (take_buf) begin
                m_bv = 1'b0; m_losses = 0;
            end else if (m_bv) begin
                if (pipe_won) m_losses++;
            end else if (bus.md_valid) begin
                m_bv = 1'b1; m_rd = bus.md_rd; m_data = bus.md_data; m_losses = 0;
            end
        end

        @(posedge clock);
        #1;
        chk("we", 32'(bus.ctrl_writeEnable), 32'(e_we));
        chk("wreg", 32'(bus.ctrl_writeReg), 32'(e_rd));
        if (e_data_care) chk("wdata", bus.data_writeReg, e_data);
`ifdef WB_FWD_EN
        chk("fwdA", 32'(bus.fwd_hitA), 32'(e_we && (e_rd == bus.ctrl_readRegA)));
        chk("fwdB", 32'(bus.fwd_hitB), 32'(e_we && (e_rd == bus.ctrl_readRegB)));
`endif
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
    endtask

    initial begin
        m_bv = 1'b0; m_rd = '0; m_data = '0; m_losses = 0;
        e_we = 1'b0; e_rd = '0; e_data = '0; e_data_care = 1'b1; last_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("rst_data", bus.data_writeReg, 32'd0);

        // Single pipeline write
        drive(1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 1);
        tick();
        chk("p26_reg", 32'(bus.ctrl_writeReg), 32'd5);
        chk("p26_data", bus.data_writeReg, 32'h1234);

        // Multdiv result: accepted in N, md_ready low in N+1, written at N+2
        drive(0, 0, 0, 0, 1, 5'd9, 32'hDEADBEEF, 0, 0, 1);
        tick();
        idle(1);
        chk("md27_reg", 32'(bus.ctrl_writeReg), 32'd9);
        chk("md27_data", bus.data_writeReg, 32'hDEADBEEF);

        // Exception beats a concurrent pipeline write, which is dropped
        drive(1, 1, 5'd7, 32'h77, 0, 0, 0, 1, 32'h2, 1);
        tick();
        chk("exc_reg", 32'(bus.ctrl_writeReg), 32'd30);
        idle(2);

        // Starvation: four pipe wins, then a forced buffer write with stall
        drive(0, 0, 0, 0, 1, 5'd3, 32'hCAFE, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'(11 + i), 32'(100 + i), 0, 0, 0, 0, 0, 1);
            tick();
            chk("starve_pipe", 32'(bus.ctrl_writeReg), 32'(11 + i));
        end
        drive(1, 1, 5'd15, 32'h15, 0, 0, 0, 0, 0, 1);
        tick();
        chk("force_stall", 32'(last_stall), 32'd1);
        chk("force_reg", 32'(bus.ctrl_writeReg), 32'd3);
        drive(1, 1, 5'd15, 32'h15, 0, 0, 0, 0, 0, 1);
        tick();
        chk("retry_reg", 32'(bus.ctrl_writeReg), 32'd15);

        // Write to r0 is suppressed
        drive(1, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 1);
        tick();
        chk("r0_we", 32'(bus.ctrl_writeEnable), 32'd0);

        // Reset with a full buffer discards the result
        drive(0, 0, 0, 0, 1, 5'd21, 32'hBAD, 0, 0, 1);
        tick();
        drive(1, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst31_reg", 32'(bus.ctrl_writeReg), 32'd0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 9) == 0), $urandom,
                  1'($urandom_range(0, 63) != 0));
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
